clk_div_programmable: RTL and testbench
=======================================

Name: clk_div_programmable

Overview:
Runtime-programmable clock divider, successor to the fixed divide-by-64 generator. Derives a divided clock and a one-cycle period strobe from the system clock. Divisor, high time and duty mode are software-loadable, with glitch-free shadow update at period boundaries. Feeds PWM filter and sampling logic that need rates other than 781250 Hz.

Parameters:
WIDTH, 16, bit width of divisor, high-time and internal counter.
DEFAULT_DIV, 64, active divisor after reset (50 MHz / 64 = 781250 Hz).
DEFAULT_HIGH, 32, active high-time after reset.
DEFAULT_MODE, 0, active mode after reset (0 = auto 50 %, 1 = programmed duty).

Ports:
CLK_50M  input  1  system clock; all logic on its rising edge.
RST  input  1  asynchronous active-low reset.
EN  input  1  run enable; low holds the divider idle.
LOAD  input  1  single-cycle request to capture DIV_VAL/HIGH_VAL/MODE into the shadow registers.
DIV_VAL  input  WIDTH  requested period N, in CLK_50M cycles.
HIGH_VAL  input  WIDTH  requested high time H, in cycles (mode 1 only).
MODE  input  1  0 = H is N>>1; 1 = H is HIGH_VAL.
CLK_OUT  output  1  divided clock, registered.
TICK  output  1  one-cycle pulse in the first cycle of every period, registered.
PENDING  output  1  shadow holds values not yet applied.

Behaviour:
- Reset (RST low, async):
  - Outputs: CLK_OUT=0, TICK=0, PENDING=0.
  - Internal: counter cnt=0, state=IDLE.
  - Active registers: N=DEFAULT_DIV, H=DEFAULT_HIGH, mode=DEFAULT_MODE. Shadow registers take the same values.
  - Reset mid-period truncates the output immediately.
- Clamping, applied when shadow is copied to active, combinational on shadow:
  - N < 2 gives N=2.
  - Mode 0: H = N>>1 (floor; odd N has the shorter high phase).
  - Mode 1: H clamped to [1, N-1].
  - Clamped results stay WIDTH bits wide. The counter compares with cnt == N-1; there is no overflow at N = 2^WIDTH-1.
- States: IDLE, RUN.
- IDLE:
  - EN=0: cnt<=0, CLK_OUT<=0, TICK<=0. If PENDING, shadow goes to active at this edge and PENDING<=0.
  - EN=1: go to RUN, cnt<=0, CLK_OUT<=1, TICK<=1. Latency from EN rising to CLK_OUT/TICK high is 1 edge.
- RUN:
  - EN=0: go to IDLE with the IDLE EN=0 actions; output truncated.
  - cnt == N-1 (boundary): cnt<=0. If PENDING, apply shadow and clear PENDING. Then CLK_OUT<=1, TICK<=1.
  - Otherwise: cnt<=cnt+1, CLK_OUT<=(cnt+1 < H), TICK<=0.
  - Result: CLK_OUT high for H cycles, low for N-H cycles. TICK asserts once per N cycles, aligned with the CLK_OUT rising edge.
- LOAD:
  - Captures DIV_VAL, HIGH_VAL and MODE into the shadow registers; PENDING<=1 at that edge.
  - LOAD while PENDING overwrites the shadow; last write wins and only one apply occurs.
  - LOAD in the same cycle as a boundary: the boundary applies the old shadow, if pending, before the capture. The new capture sets PENDING and is applied at the next boundary, giving exactly one more period of the old settings.
  - LOAD while IDLE with EN=0: applied on the following edge.
- Active values never change mid-period, so CLK_OUT has no runt pulses except on EN drop or reset.

Decomposition:
- Package clk_div_pkg:
  - state enum (IDLE, RUN).
  - mode constants MODE_AUTO=0, MODE_DUTY=1.
  - function clamp_cfg(N, H, mode) returning clamped N and H.
- Sub-module clk_div_shadow_cfg: LOAD capture, PENDING flag and apply-on-request. The top-level holds the counter and FSM.

Test Plan:
- Reset defaults: release RST, EN=1, no LOAD. Expect TICK every 64 cycles; CLK_OUT 32 high / 32 low; first TICK 1 edge after EN.
- Mode 1 duty: LOAD N=10, H=3, MODE=1 mid-period. Expect the current 64-cycle period to complete, then CLK_OUT 3 high / 7 low. PENDING is high from LOAD until the boundary edge.
- Clamping:
  - N=1 gives period 2, H=1.
  - Mode 1, N=5, H=0 gives H=1.
  - Mode 1, N=5, H=9 gives H=4.
  - Mode 0, N=7 gives 3 high / 4 low.
- LOAD at boundary and double LOAD:
  - LOAD N=8 coinciding with cnt==N-1: exactly one more old period, then period 8.
  - Two LOADs (N=12, then N=6) inside one period: only period 6 appears.
- EN toggling: drop EN at cnt=5 with N=20. CLK_OUT and TICK go 0 at the next edge. Re-raise EN: CLK_OUT=1 and TICK=1 after 1 edge, cnt restarts at 0.
- Async reset mid-run: assert RST between clock edges. All outputs 0 immediately and active values return to defaults. After release, the default 64-cycle behaviour resumes.

Source files
------------

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared types and config clamping for the programmable clock divider
package clk_div_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic MODE_AUTO = 1'b0;
  localparam logic MODE_DUTY = 1'b1;
  typedef struct packed {
    logic [31:0] n;
    logic [31:0] h;
  } cfg_t;
  function automatic cfg_t clamp_cfg(input logic [31:0] n, input logic [31:0] h, input logic mode);
    cfg_t c;
    c.n = (n < 32'd2) ? 32'd2 : n;
    c.h = (mode == MODE_DUTY) ? ((h == 32'd0) ? 32'd1 : (h >= c.n) ? c.n - 32'd1 : h) : c.n >> 1;
    return c;
  endfunction
endpackage

// File: rtl/clk_div_shadow_cfg.sv
// clk_div_shadow_cfg: captures LOAD requests into a shadow and applies them, clamped, on request
module clk_div_shadow_cfg
  import clk_div_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int DEFAULT_DIV  = 64,
  parameter int DEFAULT_HIGH = 32,
  parameter bit DEFAULT_MODE = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_div,
  input  logic [WIDTH-1:0] i_high,
  input  logic             i_mode,
  input  logic             i_apply,
  output logic             o_pending,
  output logic [WIDTH-1:0] o_n,
  output logic [WIDTH-1:0] o_h
);
  logic [WIDTH-1:0] r_div, r_high, r_n, r_h;
  logic             r_mode, r_pending;
  cfg_t             w_cfg;
  logic             w_unused_cfg;
  assign w_cfg        = clamp_cfg(32'(r_div), 32'(r_high), r_mode);
  assign w_unused_cfg = ^{w_cfg.n, w_cfg.h};
  // apply reads the old shadow before a same-edge LOAD overwrites it
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div     <= WIDTH'(DEFAULT_DIV);
      r_high    <= WIDTH'(DEFAULT_HIGH);
      r_mode    <= DEFAULT_MODE;
      r_n       <= WIDTH'(DEFAULT_DIV);
      r_h       <= WIDTH'(DEFAULT_HIGH);
      r_pending <= 1'b0;
    end else begin
      if (i_apply) begin
        r_n <= w_cfg.n[WIDTH-1:0];
        r_h <= w_cfg.h[WIDTH-1:0];
      end
      if (i_load) begin
        r_div  <= i_div;
        r_high <= i_high;
        r_mode <= i_mode;
      end
      r_pending <= i_load | (r_pending & ~i_apply);
    end
  end
  assign o_pending = r_pending;
  assign o_n       = r_n;
  assign o_h       = r_h;
endmodule

// File: rtl/clk_div_programmable.sv
// clk_div_programmable: runtime-programmable clock divider with period strobe and glitch-free reload
module clk_div_programmable
  import clk_div_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int DEFAULT_DIV  = 64,
  parameter int DEFAULT_HIGH = 32,
  parameter bit DEFAULT_MODE = 1'b0
) (
  input  logic             CLK_50M,
  input  logic             RST,
  input  logic             EN,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] DIV_VAL,
  input  logic [WIDTH-1:0] HIGH_VAL,
  input  logic             MODE,
  output logic             CLK_OUT,
  output logic             TICK,
  output logic             PENDING
);
  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_cnt, w_cnt_nxt, w_n, w_h;
  logic             r_clk, r_tick, w_clk_nxt, w_tick_nxt, w_apply, w_bound, w_start;
  clk_div_shadow_cfg #(
    .WIDTH(WIDTH), .DEFAULT_DIV(DEFAULT_DIV), .DEFAULT_HIGH(DEFAULT_HIGH), .DEFAULT_MODE(DEFAULT_MODE)
  ) u_cfg (
    .i_clk(CLK_50M), .i_rst_n(RST), .i_load(LOAD), .i_div(DIV_VAL), .i_high(HIGH_VAL),
    .i_mode(MODE), .i_apply(w_apply), .o_pending(PENDING), .o_n(w_n), .o_h(w_h)
  );
  always_ff @(posedge CLK_50M or negedge RST) begin
    if (!RST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_clk   <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_clk   <= w_clk_nxt;
      r_tick  <= w_tick_nxt;
    end
  end
  always_comb w_state_nxt = EN ? RUN : IDLE;
  // a period starts on leaving IDLE or at the end of the current period
  always_comb begin
    w_bound    = (r_state == RUN) && (r_cnt == w_n - WIDTH'(1));
    w_start    = (r_state == IDLE) || w_bound;
    w_apply    = PENDING && (!EN || w_bound);
    w_cnt_nxt  = (!EN || w_start) ? '0 : r_cnt + WIDTH'(1);
    w_clk_nxt  = EN && (w_start || (w_cnt_nxt < w_h));
    w_tick_nxt = EN && w_start;
  end
  assign CLK_OUT = r_clk;
  assign TICK    = r_tick;
endmodule

// File: tb/tb_clk_div_programmable.sv
// tb_clk_div_programmable: scoreboard bench comparing per-cycle CLK_OUT/TICK/PENDING to expected streams
module tb_clk_div_programmable;
  logic        CLK_50M = 1'b0;
  logic        RST = 1'b0, EN = 1'b0, LOAD = 1'b0, MODE = 1'b0;
  logic [15:0] DIV_VAL = '0, HIGH_VAL = '0;
  logic        CLK_OUT, TICK, PENDING;
  logic [2:0]  sb[$];
  int          tests = 0, fails = 0, idx = 0;

  clk_div_programmable dut (
    .CLK_50M(CLK_50M), .RST(RST), .EN(EN), .LOAD(LOAD), .DIV_VAL(DIV_VAL),
    .HIGH_VAL(HIGH_VAL), .MODE(MODE), .CLK_OUT(CLK_OUT), .TICK(TICK), .PENDING(PENDING)
  );

  always #5 CLK_50M = ~CLK_50M;

  // expected {CLK_OUT, TICK, PENDING} for the first len cycles of an n/h period; PENDING high from index pf
  function automatic void push_period(input int n, input int h, input int pf, input int len);
    for (int i = 0; i < len; i++) sb.push_back({i < h, i == 0, i >= pf});
  endfunction

  // advance k edges, popping one expected entry per edge and comparing 1 time unit after it
  task automatic cycles(input int k);
    logic [2:0] e;
    for (int i = 0; i < k; i++) begin
      @(posedge CLK_50M);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        tests++;
        if ({CLK_OUT, TICK, PENDING} !== e) begin
          fails++;
          $display("FAIL stream[%0d] t=%0t: got clk=%b tick=%b pend=%b, want clk=%b tick=%b pend=%b",
                   idx, $time, CLK_OUT, TICK, PENDING, e[2], e[1], e[0]);
        end
        idx++;
      end
      @(negedge CLK_50M);
    end
  endtask

  task automatic load_at(input int k, input logic [15:0] n, input logic [15:0] h, input logic m,
                         input int cur_n, input int cur_h, input int new_n, input int new_h, input int reps);
    push_period(cur_n, cur_h, k, cur_n);
    for (int r = 0; r < reps; r++) push_period(new_n, new_h, new_n, new_n);
    cycles(k);
    LOAD = 1'b1; DIV_VAL = n; HIGH_VAL = h; MODE = m;
    cycles(1);
    LOAD = 1'b0;
    cycles(cur_n + reps * new_n - k - 1);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge CLK_50M);
    tests += 3;
    if (CLK_OUT !== 1'b0) begin fails++; $display("FAIL reset_clk: got %b want 0", CLK_OUT); end
    if (TICK !== 1'b0) begin fails++; $display("FAIL reset_tick: got %b want 0", TICK); end
    if (PENDING !== 1'b0) begin fails++; $display("FAIL reset_pending: got %b want 0", PENDING); end
    RST = 1'b1;
    sb.push_back(3'b000); sb.push_back(3'b001); sb.push_back(3'b000);
    cycles(1);
    LOAD = 1'b1; DIV_VAL = 16'd64; HIGH_VAL = 16'd32; MODE = 1'b0;
    cycles(1);
    LOAD = 1'b0;
    cycles(1);
  endtask

  task automatic test_defaults;
    EN = 1'b1;
    for (int r = 0; r < 3; r++) push_period(64, 32, 64, 64);
    cycles(192);
  endtask

  task automatic test_duty;
    load_at(10, 16'd10, 16'd3, 1'b1, 64, 32, 10, 3, 3);
  endtask

  task automatic test_clamp;
    load_at(1, 16'd1, 16'd7, 1'b0, 10, 3, 2, 1, 3);
    load_at(1, 16'd5, 16'd0, 1'b1, 2, 1, 5, 1, 2);
    load_at(2, 16'd5, 16'd9, 1'b1, 5, 1, 5, 4, 2);
    load_at(3, 16'd7, 16'd1, 1'b0, 5, 4, 7, 3, 2);
  endtask

  task automatic test_load_boundary;
    load_at(0, 16'd8, 16'd0, 1'b0, 7, 3, 8, 4, 2);
  endtask

  task automatic test_double_load;
    push_period(8, 4, 2, 8);
    push_period(6, 3, 6, 6);
    push_period(6, 3, 6, 6);
    cycles(2);
    LOAD = 1'b1; DIV_VAL = 16'd12; HIGH_VAL = 16'd0; MODE = 1'b0;
    cycles(1);
    DIV_VAL = 16'd6;
    cycles(1);
    LOAD = 1'b0;
    cycles(16);
  endtask

  task automatic test_en_toggle;
    load_at(1, 16'd20, 16'd0, 1'b0, 6, 3, 20, 10, 1);
    push_period(20, 10, 20, 6);
    for (int i = 0; i < 3; i++) sb.push_back(3'b000);
    push_period(20, 10, 20, 20);
    push_period(20, 10, 20, 20);
    cycles(6);
    EN = 1'b0;
    cycles(3);
    EN = 1'b1;
    cycles(40);
  endtask

  task automatic test_async_reset;
    push_period(20, 10, 3, 7);
    cycles(3);
    LOAD = 1'b1; DIV_VAL = 16'd3; HIGH_VAL = 16'd0; MODE = 1'b0;
    cycles(1);
    LOAD = 1'b0;
    cycles(3);
    #2 RST = 1'b0;
    #1;
    tests += 3;
    if (CLK_OUT !== 1'b0) begin fails++; $display("FAIL async_clk: got %b want 0", CLK_OUT); end
    if (TICK !== 1'b0) begin fails++; $display("FAIL async_tick: got %b want 0", TICK); end
    if (PENDING !== 1'b0) begin fails++; $display("FAIL async_pending: got %b want 0", PENDING); end
    @(negedge CLK_50M);
    tests++;
    if ({CLK_OUT, TICK, PENDING} !== 3'b000) begin
      fails++;
      $display("FAIL async_hold: got %b want 000", {CLK_OUT, TICK, PENDING});
    end
    RST = 1'b1;
    push_period(64, 32, 64, 64);
    push_period(64, 32, 64, 64);
    cycles(128);
  endtask

  initial begin
    test_reset;
    test_defaults;
    test_duty;
    test_clamp;
    test_load_boundary;
    test_double_load;
    test_en_toggle;
    test_async_reset;
    tests++;
    if (sb.size() != 0) begin fails++; $display("FAIL sb_drain: got %0d left want 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
